vrp_fifo_v2: RTL and testbench
==============================

// Module: vrp_fifo_v2
// PURPOSE
//  Next-generation valid/ready FIFO for payload buffering between pipeline stages.
//  Adds non-power-of-two DEPTH, occupancy count, runtime almost-full/almost-empty
//  thresholds and a synchronous flush. Drop-in for point-to-point streams.
//  Optional output register for timing closure on the pld_m path.
// PARAMETERS
//  PLD_WIDTH   32                    payload width in bits (>=1)
//  DEPTH       8                     entry capacity; any integer >=2, not limited to powers of two
//  PNTR_WIDTH  $clog2(DEPTH)         read/write index width
//  CNT_WIDTH   $clog2(DEPTH+1)       occupancy/threshold width
// PORTS
//  clk           in   1          clock; all logic on posedge
//  rst           in   1          asynchronous, active-high reset
//  flush         in   1          synchronous flush: discard all entries
//  vld_s         in   1          slave-side valid
//  rdy_s         out  1          slave-side ready
//  pld_s         in   PLD_WIDTH  slave-side payload
//  vld_m         out  1          master-side valid
//  pld_m         out  PLD_WIDTH  master-side payload (head entry)
//  rdy_m         in   1          master-side ready
//  af_thr        in   CNT_WIDTH  almost-full threshold (quasi-static)
//  ae_thr        in   CNT_WIDTH  almost-empty threshold (quasi-static)
//  count         out  CNT_WIDTH  current occupancy, 0..DEPTH
//  almost_full   out  1          count >= af_thr
//  almost_empty  out  1          count <= ae_thr
// BEHAVIOUR
//  - Reset: wr/rd index=0, count=0, vld_m=0, rdy_s=1, pld_m don't-care,
//    almost_empty=1, almost_full=(af_thr==0). Reset mid-transfer drops all content.
//  - push = vld_s&rdy_s; pop = vld_m&rdy_m. Transfers complete on the posedge.
//  - rdy_s = !full & !flush; vld_m = !empty & !flush. No combinational path vld_s->vld_m or rdy_m->rdy_s.
//  - full = (count==DEPTH); empty = (count==0). count, full, empty all derive from the count register.
//  - Index wrap: index==DEPTH-1 -> 0 on advance (explicit compare, not modulo 2^PNTR_WIDTH).
//  - count_next = count + push - pop. Simultaneous push & pop: count unchanged, both indices advance.
//  - Full: rdy_s=0. A pop in the same cycle frees a slot at the next cycle only (no same-cycle pass).
//  - Empty: vld_m=0. No bypass, so a push is visible at vld_m no earlier than the next cycle.
//  - Latency: push at edge N -> vld_m=1 and pld_m valid in cycle after N (1 cycle). Throughput 1/cycle.
//  - Flush has priority: indices and count -> 0 at the edge. rdy_s/vld_m forced 0 during flush,
//    so no transfer occurs in a flush cycle.
//  - almost_full/almost_empty: combinational from count and thresholds. af_thr>DEPTH -> never asserted.
//  - Memory has no reset. Written only on push at wr index.
// CONFIGURATION
//  VRP_FIFO_V2_OREG_EN defined: pld_m/vld_m driven from an output register.
//    The head entry is prefetched from memory into it. The output slot counts toward count,
//    so capacity stays DEPTH. Push->vld_m latency becomes 2 cycles and throughput stays 1/cycle.
//    Flush and reset clear the output register valid.
//  Undefined: pld_m read combinationally from memory at rd index, with 1-cycle latency.
// STRUCTURE
//  vrp_fifo_pkg: function for width of a count 0..N; localparam-free typedef helpers
//    cnt_t/pntr_t are parameterised in-module, so the package holds functions only.
//  Sub-module vrp_fifo_oreg: output register stage, instantiated only under VRP_FIFO_V2_OREG_EN.
//  Core: dual index registers, count register, memory array, status compare logic.
// TESTING
//  - DEPTH=5: 5 pushes, rdy_m=0 -> count=5, rdy_s=0, almost_full (af_thr=4) =1. 6th vld_s not accepted.
//  - DEPTH=5: 12 push/pop interleaved, data 0..11 -> output order 0..11, index wraps 4->0 twice, no loss.
//  - Full + simultaneous pop (vld_s=1,rdy_m=1) -> rdy_s=0 that cycle, count 5->4, next cycle rdy_s=1.
//  - Steady stream vld_s=rdy_m=1 for 20 cycles -> one transfer per cycle, count constant (1, or 2 with OREG).
//  - count=3, assert flush with vld_s=1 -> vld_m=rdy_s=0 that cycle, count=0 next cycle, pushed data dropped.
//  - Assert rst with count=4 mid-stream -> immediately vld_m=0, count=0, rdy_s=1, almost_empty=1.

Source files
------------

// File: rtl/vrp_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vrp_fifo_pkg
//  Description : Shared width helpers for the vrp_fifo_v2 valid/ready FIFO.
//                The index and occupancy types are parameterised in the
//                module, so only functions live here.
//  Revision    : 1.0 - initial release
// ============================================================================
package vrp_fifo_pkg;

  // Bits needed to hold a count ranging over 0..n (inclusive).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index n entries (0..n-1), never less than one.
  function automatic int unsigned pntr_width(input int unsigned n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vrp_fifo_oreg.sv
`default_nettype none
// ============================================================================
//  Module      : vrp_fifo_oreg
//  Description : Output register stage for vrp_fifo_v2. Holds the prefetched
//                head entry and its valid flag so pld_m/vld_m come straight
//                from flops.
//  Revision    : 1.0 - initial release
// ============================================================================
module vrp_fifo_oreg #(
  parameter int PLD_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 load_i,
  input  logic                 pop_i,
  input  logic [PLD_WIDTH-1:0] pld_i,
  output logic                 vld_o,
  output logic [PLD_WIDTH-1:0] pld_o
);

  logic                 vld_q, vld_d;
  logic [PLD_WIDTH-1:0] pld_q;

  // Valid next-state: flush clears, a load refills, a pop without refill empties.
  always_comb begin
    vld_d = vld_q;
    if (flush_i)     vld_d = 1'b0;
    else if (load_i) vld_d = 1'b1;
    else if (pop_i)  vld_d = 1'b0;
  end

  // Valid flag register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= vld_d;
  end

  // Payload register needs no reset; it is qualified by vld_q.
  always_ff @(posedge clk) begin
    if (load_i) pld_q <= pld_i;
  end

  assign vld_o = vld_q;
  assign pld_o = pld_q;

endmodule
`default_nettype wire

// File: rtl/vrp_fifo_v2.sv
`default_nettype none
// ============================================================================
//  Module      : vrp_fifo_v2
//  Description : Valid/ready FIFO with arbitrary DEPTH (>=2), occupancy count,
//                runtime almost-full/almost-empty thresholds and synchronous
//                flush. Optional output register enabled by defining
//                VRP_FIFO_V2_OREG_EN (adds one cycle of push->vld_m latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module vrp_fifo_v2
  import vrp_fifo_pkg::*;
#(
  parameter int PLD_WIDTH  = 32,
  parameter int DEPTH      = 8,
  parameter int PNTR_WIDTH = pntr_width(DEPTH),
  parameter int CNT_WIDTH  = cnt_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 vld_s,
  output logic                 rdy_s,
  input  logic [PLD_WIDTH-1:0] pld_s,
  output logic                 vld_m,
  output logic [PLD_WIDTH-1:0] pld_m,
  input  logic                 rdy_m,
  input  logic [CNT_WIDTH-1:0] af_thr,
  input  logic [CNT_WIDTH-1:0] ae_thr,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 almost_full,
  output logic                 almost_empty
);

  logic [PNTR_WIDTH-1:0] wr_q, wr_d;
  logic [PNTR_WIDTH-1:0] rd_q, rd_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [PLD_WIDTH-1:0]  mem_q [DEPTH];

  logic full, empty, push, pop, rd_adv;

  // All status derives from the count register, never from index compares.
  assign full  = (count_q == CNT_WIDTH'(DEPTH));
  assign empty = (count_q == '0);
  assign rdy_s = !full && !flush;
  assign push  = vld_s && rdy_s;
  assign pop   = vld_m && rdy_m;

`ifdef VRP_FIFO_V2_OREG_EN
  logic oreg_vld;
  logic mem_nonempty;
  logic prefetch;

  // Entries still in memory exclude the one parked in the output register.
  assign mem_nonempty = ((count_q - CNT_WIDTH'(oreg_vld)) != '0);
  // Refill the output slot whenever it is free or draining this cycle.
  assign prefetch     = mem_nonempty && (!oreg_vld || pop) && !flush;
  assign rd_adv       = prefetch;
  assign vld_m        = oreg_vld && !flush;

  vrp_fifo_oreg #(
    .PLD_WIDTH (PLD_WIDTH)
  ) u_oreg (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .load_i  (prefetch),
    .pop_i   (pop),
    .pld_i   (mem_q[rd_q]),
    .vld_o   (oreg_vld),
    .pld_o   (pld_m)
  );
`else
  // Head entry read straight from memory; push visible one cycle later.
  assign rd_adv = pop;
  assign vld_m  = !empty && !flush;
  assign pld_m  = mem_q[rd_q];
`endif

  // Next-state for indices and occupancy; flush overrides everything.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push)   wr_d = (wr_q == PNTR_WIDTH'(DEPTH - 1)) ? '0 : wr_q + PNTR_WIDTH'(1);
      if (rd_adv) rd_d = (rd_q == PNTR_WIDTH'(DEPTH - 1)) ? '0 : rd_q + PNTR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Index and count registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage array, written only on an accepted push; contents not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= pld_s;
  end

  assign count        = count_q;
  assign almost_full  = (count_q >= af_thr);
  assign almost_empty = (count_q <= ae_thr);

endmodule
`default_nettype wire

// File: tb/tb_vrp_fifo_v2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vrp_fifo_v2
//  Description : Directed self-checking bench for vrp_fifo_v2, DEPTH=5.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vrp_fifo_v2;

  localparam int PW = 16;
  localparam int DP = 5;
  localparam int CW = 3;
`ifdef VRP_FIFO_V2_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          vld_s;
  logic          rdy_s;
  logic [PW-1:0] pld_s;
  logic          vld_m;
  logic [PW-1:0] pld_m;
  logic          rdy_m;
  logic [CW-1:0] af_thr;
  logic [CW-1:0] ae_thr;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          almost_empty;

  int n_chk  = 0;
  int n_fail = 0;

  vrp_fifo_v2 #(
    .PLD_WIDTH (PW),
    .DEPTH     (DP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .vld_s        (vld_s),
    .rdy_s        (rdy_s),
    .pld_s        (pld_s),
    .vld_m        (vld_m),
    .pld_m        (pld_m),
    .rdy_m        (rdy_m),
    .af_thr       (af_thr),
    .ae_thr       (ae_thr),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are set and outputs checked on the negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int sent;
    int rcvd;

    rst = 1'b1; flush = 1'b0; vld_s = 1'b0; pld_s = '0; rdy_m = 1'b0;
    af_thr = 3'd4; ae_thr = 3'd1;
    @(negedge clk);

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_vld_m", vld_m, 0);
    chk("rst_rdy_s", rdy_s, 1);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    af_thr = 3'd0; #1;
    chk("rst_af_thr0", almost_full, 1);
    af_thr = 3'd4;
    rst = 1'b0;
    @(negedge clk);

    // Fill to full with consumer stalled
    vld_s = 1'b1; rdy_m = 1'b0;
    for (int i = 0; i < DP; i++) begin
      pld_s = PW'(16'h0100 + i);
      chk("fill_rdy_s", rdy_s, 1);
      chk("fill_count", count, i);
      chk("fill_ae", almost_empty, (i <= 1));
      chk("fill_af", almost_full, (i >= 4));
      step();
    end
    pld_s = 16'hDEAD;
    chk("full_count", count, 5);
    chk("full_rdy_s", rdy_s, 0);
    chk("full_af", almost_full, 1);
    chk("full_vld_m", vld_m, 1);
    chk("full_head", pld_m, 16'h0100);
    af_thr = 3'd7; #1;
    chk("full_af_thr_gt_depth", almost_full, 0);
    af_thr = 3'd4;
    step();
    chk("full_6th_rejected", count, 5);

    // Full with simultaneous pop: slot frees only next cycle
    rdy_m = 1'b1;
    chk("fullpop_rdy_s", rdy_s, 0);
    chk("fullpop_head", pld_m, 16'h0100);
    step();
    chk("fullpop_count", count, 4);
    chk("fullpop_rdy_s_next", rdy_s, 1);
    vld_s = 1'b0;
    for (int k = 1; k < DP; k++) begin
      chk("drain_vld_m", vld_m, 1);
      chk("drain_data", pld_m, 16'h0100 + k);
      step();
    end
    rdy_m = 1'b0;
    chk("drain_count", count, 0);
    chk("drain_vld_m_low", vld_m, 0);

    // Interleaved push/pop of 0..11 across two index wraps
    sent = 0; rcvd = 0;
    for (int c = 0; c < 60 && rcvd < 12; c++) begin
      vld_s = (sent < 12);
      pld_s = PW'(sent);
      rdy_m = (c % 3 != 0);
      #1;
      if (vld_m && rdy_m) begin
        chk("ilv_data", pld_m, rcvd);
        rcvd++;
      end
      if (vld_s && rdy_s) sent++;
      step();
    end
    vld_s = 1'b0; rdy_m = 1'b0;
    chk("ilv_rcvd", rcvd, 12);
    chk("ilv_count", count, 0);

    // Steady stream: one transfer per cycle, constant occupancy
    vld_s = 1'b1; rdy_m = 1'b1;
    for (int c = 0; c < 20; c++) begin
      pld_s = PW'(16'h0200 + c);
      #1;
      chk("strm_rdy_s", rdy_s, 1);
      if (c >= LAT) begin
        chk("strm_count", count, LAT);
        chk("strm_vld_m", vld_m, 1);
        chk("strm_data", pld_m, 16'h0200 + c - LAT);
      end
      step();
    end
    vld_s = 1'b0;
    rcvd = 20 - LAT;
    for (int c = 0; c < 10 && count != 0; c++) begin
      if (vld_m) begin
        chk("strm_tail", pld_m, 16'h0200 + rcvd);
        rcvd++;
      end
      step();
    end
    rdy_m = 1'b0;
    chk("strm_total", rcvd, 20);
    chk("strm_empty", count, 0);

    // Flush with count=3 and a concurrent push attempt
    vld_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pld_s = PW'(16'h0400 + i);
      step();
    end
    chk("fl_count3", count, 3);
    flush = 1'b1; pld_s = 16'hBEEF; #1;
    chk("fl_vld_m", vld_m, 0);
    chk("fl_rdy_s", rdy_s, 0);
    step();
    flush = 1'b0; vld_s = 1'b0;
    chk("fl_count0", count, 0);
    chk("fl_vld_m_after", vld_m, 0);
    step();
    chk("fl_dropped", vld_m, 0);
    vld_s = 1'b1; pld_s = 16'h0055;
    step();
    vld_s = 1'b0;
    for (int i = 1; i < LAT; i++) step();
    chk("fl_post_vld", vld_m, 1);
    chk("fl_post_data", pld_m, 16'h0055);
    rdy_m = 1'b1;
    step();
    rdy_m = 1'b0;
    chk("fl_post_empty", count, 0);

    // Asynchronous reset mid-stream with count=4
    vld_s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pld_s = PW'(16'h0500 + i);
      step();
    end
    vld_s = 1'b0;
    chk("rs_count4", count, 4);
    rst = 1'b1; #1;
    chk("rs_vld_m", vld_m, 0);
    chk("rs_count", count, 0);
    chk("rs_rdy_s", rdy_s, 1);
    chk("rs_ae", almost_empty, 1);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rs_stays_empty", vld_m, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard stop in case a step sequence is ever stuck.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
